// File: rtl/dds_pkg.sv
// Shared types, constants and the quarter-wave sine lookup for the DDS generator.
package dds_pkg;

   localparam int PHASE_W = 32;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;

   typedef enum logic [1:0] {
      SINE     = 2'd0,
      SQUARE   = 2'd1,
      TRIANGLE = 2'd2,
      SAW      = 2'd3
   } wave_t;

   localparam logic [PHASE_W-1:0] FW_TABLE [0:3] = '{
      32'h0100_0000, 32'h0200_0000, 32'h0400_0000, 32'h0080_0000
   };

   // First quarter (entries 0..64) of round(127.5 + 127.5*sin(2*pi*i/256)).
   localparam logic [DATA_W-1:0] SINE_Q [0:64] = '{
      8'd128,
      8'd131, 8'd134, 8'd137, 8'd140, 8'd143, 8'd146, 8'd149, 8'd152,
      8'd155, 8'd158, 8'd162, 8'd165, 8'd167, 8'd170, 8'd173, 8'd176,
      8'd179, 8'd182, 8'd185, 8'd188, 8'd190, 8'd193, 8'd196, 8'd198,
      8'd201, 8'd203, 8'd206, 8'd208, 8'd211, 8'd213, 8'd215, 8'd218,
      8'd220, 8'd222, 8'd224, 8'd226, 8'd228, 8'd230, 8'd232, 8'd234,
      8'd235, 8'd237, 8'd238, 8'd240, 8'd241, 8'd243, 8'd244, 8'd245,
      8'd246, 8'd248, 8'd249, 8'd250, 8'd250, 8'd251, 8'd252, 8'd253,
      8'd253, 8'd254, 8'd254, 8'd254, 8'd255, 8'd255, 8'd255, 8'd255
   };

   // Second half mirrors the first about 127.5; addr 128 is the tie case that rounds up.
   function automatic logic [DATA_W-1:0] sine_lookup(input logic [ADDR_W-1:0] addr);
      logic [6:0]        ph;
      logic [6:0]        q;
      logic [DATA_W-1:0] mag;
      ph  = addr[6:0];
      q   = (ph > 7'd64) ? (7'd0 - ph) : ph;
      mag = SINE_Q[q];
      if (!addr[7]) begin
         sine_lookup = mag;
      end else if (ph == 7'd0) begin
         sine_lookup = 8'd128;
      end else begin
         sine_lookup = 8'd255 - mag;
      end
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low push-button debouncer: two-flop synchroniser, saturating low counter,
// single registered press pulse on the CNT_MAX-th consecutive low sample.
module key_debounce #(
   parameter int CNT_MAX = 1_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_in,
   output logic press_pulse
);

   localparam int               CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(CNT_MAX - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   always_comb begin
      sync1_d = key_in;
      sync2_d = sync1_q;
      if (sync2_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TOP) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      pulse_d = ~sync2_q && (cnt_q == CNT_ARM);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign press_pulse = pulse_q;

endmodule

// File: rtl/dds_wave_gen.sv
// DDS signal generator: button-selected waveform and frequency word, 32-bit phase
// accumulator, registered 8-bit DAC sample. Option macro: DDS_DA_INVERT_EN.
module dds_wave_gen
   import dds_pkg::*;
#(
   parameter int CNT_MAX = 1_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              key_wave,
   input  logic              key_freq,
   output logic              da_clk,
   output logic [DATA_W-1:0] da_data,
   input  logic [7:0]        ad_data,
   input  logic              ad_otr,
   output logic              ad_clk
);

`ifdef DDS_DA_INVERT_EN
   localparam logic [DATA_W-1:0] DA_RST = 8'd255;
`else
   localparam logic [DATA_W-1:0] DA_RST = 8'd0;
`endif

   logic               wave_pulse_s;
   logic               freq_pulse_s;
   wave_t              wave_sel_q, wave_sel_d;
   logic [1:0]         freq_sel_q, freq_sel_d;
   logic [PHASE_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0]  da_data_q, da_data_d;
   logic [ADDR_W-1:0]  addr_s;
   logic [DATA_W-1:0]  sample_s;
   logic               ad_unused;

   key_debounce #(.CNT_MAX(CNT_MAX)) u_key_wave (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_wave),
      .press_pulse (wave_pulse_s)
   );

   key_debounce #(.CNT_MAX(CNT_MAX)) u_key_freq (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_in      (key_freq),
      .press_pulse (freq_pulse_s)
   );

   // The converters latch on the falling sys_clk edge, mid-way through each sample.
   assign da_clk    = ~sys_clk;
   assign ad_clk    = ~sys_clk;
   assign ad_unused = ^{ad_data, ad_otr};

   always_comb begin
      addr_s = acc_q[PHASE_W-1 -: ADDR_W];
      case (wave_sel_q)
         SINE:     sample_s = sine_lookup(addr_s);
         SQUARE:   sample_s = addr_s[7] ? 8'd0 : 8'd255;
         TRIANGLE: sample_s = addr_s[7] ? ~{addr_s[6:0], 1'b0} : {addr_s[6:0], 1'b0};
         SAW:      sample_s = addr_s;
         default:  sample_s = 8'd0;
      endcase
`ifdef DDS_DA_INVERT_EN
      da_data_d = 8'd255 - sample_s;
`else
      da_data_d = sample_s;
`endif
      // Phase is never cleared on a selection change, so the output stays continuous.
      acc_d      = acc_q + FW_TABLE[freq_sel_q];
      wave_sel_d = wave_pulse_s ? wave_t'(wave_sel_q + 2'd1) : wave_sel_q;
      freq_sel_d = freq_pulse_s ? (freq_sel_q + 2'd1) : freq_sel_q;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wave_sel_q <= SINE;
         freq_sel_q <= 2'd0;
         acc_q      <= '0;
         da_data_q  <= DA_RST;
      end else begin
         wave_sel_q <= wave_sel_d;
         freq_sel_q <= freq_sel_d;
         acc_q      <= acc_d;
         da_data_q  <= da_data_d;
      end
   end

   assign da_data = da_data_q;

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen: a cycle model pushes expected DAC samples into a
// queue on each rising edge; they are popped and compared on the following falling edge.
module tb_dds_wave_gen;

   localparam int  CNT_MAX = 5;
   localparam real PI      = 3.14159265358979;
`ifdef DDS_DA_INVERT_EN
   localparam bit  INV     = 1'b1;
`else
   localparam bit  INV     = 1'b0;
`endif

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       key_wave;
   logic       key_freq;
   logic [7:0] ad_data;
   logic       ad_otr;
   logic       da_clk;
   logic       ad_clk;
   logic [7:0] da_data;

   always #10 sys_clk = ~sys_clk;

   dds_wave_gen #(.CNT_MAX(CNT_MAX)) dut (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .key_wave (key_wave),
      .key_freq (key_freq),
      .da_clk   (da_clk),
      .da_data  (da_data),
      .ad_data  (ad_data),
      .ad_otr   (ad_otr),
      .ad_clk   (ad_clk)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   logic [7:0] sine_ref [256];

   // reference model state
   logic [1:0]  m_wave;
   logic [1:0]  m_freq;
   logic [31:0] m_acc;
   int          run_w;
   int          run_f;
   logic [2:0]  wpipe;
   logic [2:0]  fpipe;

   function automatic logic [31:0] fw_of(input logic [1:0] f);
      case (f)
         2'd0:    return 32'h0100_0000;
         2'd1:    return 32'h0200_0000;
         2'd2:    return 32'h0400_0000;
         default: return 32'h0080_0000;
      endcase
   endfunction

   function automatic logic [7:0] ref_sample(input logic [1:0] w, input logic [7:0] a);
      int         ai;
      logic [7:0] s;
      ai = int'(a);
      case (w)
         2'd0:    s = sine_ref[a];
         2'd1:    s = (ai < 128) ? 8'd255 : 8'd0;
         2'd2:    s = (ai < 128) ? 8'(2 * ai) : 8'(255 - 2 * (ai - 128));
         default: s = a;
      endcase
      return INV ? (8'd255 - s) : s;
   endfunction

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h at %0t", tag, obs, expv, $time);
      end
   endtask

   task automatic model_step();
      logic [7:0] e;
      if (sys_rst) begin
         m_wave = 2'd0;
         m_freq = 2'd0;
         m_acc  = 32'd0;
         run_w  = 0;
         run_f  = 0;
         wpipe  = 3'd0;
         fpipe  = 3'd0;
         e      = INV ? 8'd255 : 8'd0;
      end else begin
         e     = ref_sample(m_wave, m_acc[31:24]);
         m_acc = m_acc + fw_of(m_freq);
         if (wpipe[2]) m_wave = m_wave + 2'd1;
         if (fpipe[2]) m_freq = m_freq + 2'd1;
         run_w = key_wave ? 0 : run_w + 1;
         run_f = key_freq ? 0 : run_f + 1;
         // press sampled at edge e -> pulse after e+2 -> selection changes at e+3
         wpipe = {wpipe[1:0], (run_w == CNT_MAX)};
         fpipe = {fpipe[1:0], (run_f == CNT_MAX)};
      end
      exp_q.push_back(e);
   endtask

   task automatic tick();
      logic [7:0] e;
      @(posedge sys_clk);
      model_step();
      #1;
      check8("da_clk_high_phase", {7'd0, da_clk}, {7'd0, ~sys_clk});
      @(negedge sys_clk);
      check8("ad_clk_low_phase", {7'd0, ad_clk}, {7'd0, ~sys_clk});
      checks++;
      assert (exp_q.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard: observed empty queue expected a queued sample");
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check8("da_data", da_data, e);
      end
      ad_data = 8'($urandom);
      ad_otr  = 1'($urandom);
   endtask

   task automatic press(input bit on_wave, input bit on_freq, input int n);
      if (on_wave) key_wave = 1'b0;
      if (on_freq) key_freq = 1'b0;
      repeat (n) tick();
      key_wave = 1'b1;
      key_freq = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         sine_ref[i] = 8'($rtoi($floor(127.5 + 127.5 * $sin(2.0 * PI * i / 256.0) + 0.5)));
      end
      sys_rst  = 1'b0;
      key_wave = 1'b1;
      key_freq = 1'b1;
      ad_data  = 8'd0;
      ad_otr   = 1'b0;
      #1;
      sys_rst  = 1'b1;

      // reset state, then defaults: sine at 256-cycle period
      repeat (4) tick();
      sys_rst = 1'b0;
      repeat (300) tick();

      // wave select: square, triangle, sawtooth, back to sine
      repeat (4) begin
         press(1'b1, 1'b0, 6);
         repeat (260) tick();
      end

      // frequency select: x2, x4, x0.5, back to x1
      repeat (4) begin
         press(1'b0, 1'b1, 6);
         repeat (260) tick();
      end

      // too-short presses are ignored
      press(1'b1, 1'b0, 3);
      repeat (20) tick();
      press(1'b0, 1'b1, 3);
      repeat (20) tick();

      // long hold gives exactly one step (wave -> square)
      press(1'b1, 1'b0, 100);
      repeat (140) tick();

      // simultaneous presses both apply (wave -> triangle, freq -> 1)
      press(1'b1, 1'b1, 6);
      repeat (150) tick();

      // mid-waveform reset returns to sine at the base frequency
      sys_rst = 1'b1;
      repeat (3) tick();
      sys_rst = 1'b0;
      repeat (300) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
